// File: rtl/ccff_bitstream_loader_if.sv
// Word-wide bitstream source handshake for ccff_bitstream_loader.
// The source (master) presents cfg_data/cfg_valid; the loader (slave) answers with cfg_ready.
// A word transfers on a rising prog_clk edge where cfg_valid and cfg_ready are both high.
interface ccff_cfg_if #(
    parameter int unsigned WORD_W = 32
) ();
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises bitstream words MSB-first onto ccff_head and
// gates the fabric prog_clk so the chain advances only on valid bits. Exactly CHAIN_LEN
// bits are shifted per load, after which done is held until the next start.
//
// Optional build macro CCFF_TAIL_CRC_EN adds head_crc/tail_crc (CRC-16-CCITT, poly 0x1021,
// init 0xFFFF, MSB-first, no final XOR) over the bits sent into and returned from the chain.
module ccff_bitstream_loader #(
    parameter int unsigned CHAIN_LEN = 4096,
    parameter int unsigned WORD_W    = 32
) (
    input  logic      prog_clk,
    input  logic      prog_reset_n,
    input  logic      start,
    input  logic      abort,
    ccff_cfg_if.slave cfg,
    output logic      ccff_head,
    output logic      prog_clk_en,
    input  logic      ccff_tail,
    output logic      busy,
    output logic      done
`ifdef CCFF_TAIL_CRC_EN
    ,
    output logic [15:0] head_crc,
    output logic [15:0] tail_crc
`endif
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WL_W  = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] ChainLenC = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;     // bits shifted before the current cycle
    logic [WL_W-1:0]   word_left_q, word_left_d; // bits of the current word still to send
    logic [WORD_W-1:0] shreg_q, shreg_d;         // MSB is the bit on ccff_head while shifting
    logic              ccff_head_q, ccff_head_d;
    logic              prog_clk_en_q, prog_clk_en_d;

    logic              cfg_ready_c;
    logic              accept;
    logic              start_acc;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  load_base;
    logic [CNT_W-1:0]  rem_bits;
    logic [WL_W-1:0]   word_len;

    // Only the optional CRC consumes the chain loopback.
    logic unused_ccff_tail;
    assign unused_ccff_tail = ccff_tail;

    assign cnt_inc   = bit_cnt_q + CNT_W'(1);
    // A word taken in the last-bit window of SHIFT starts after the bit now being sent.
    assign load_base = (state_q == StShift) ? cnt_inc : bit_cnt_q;
    assign rem_bits  = ChainLenC - load_base;
    // Clamp to the bits the chain still needs so a partial final word drops its low bits.
    assign word_len  = (32'(rem_bits) >= WORD_W) ? WL_W'(WORD_W) : WL_W'(rem_bits);

    assign accept    = cfg.cfg_valid & cfg_ready_c;
    assign start_acc = start & ~abort & ((state_q == StIdle) | (state_q == StDone));

    // Ready: whole LOAD state, or the last bit of a word when more chain bits remain.
    always_comb begin
        cfg_ready_c = 1'b0;
        case (state_q)
            StLoad:  cfg_ready_c = ~abort;
            StShift: cfg_ready_c = ~abort & (word_left_q == WL_W'(1)) & (cnt_inc != ChainLenC);
            default: cfg_ready_c = 1'b0;
        endcase
    end

    assign cfg.cfg_ready = cfg_ready_c;

    // Next-state, counters and shift register; registered outputs follow the next state.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_left_d = word_left_q;
        shreg_d     = shreg_q;

        if (abort) begin
            // Abort wins over start, including a start in IDLE.
            state_d     = StIdle;
            bit_cnt_d   = '0;
            word_left_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d   = StLoad;
                        bit_cnt_d = '0;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        shreg_d     = cfg.cfg_data;
                        word_left_d = word_len;
                        state_d     = StShift;
                    end
                end
                StShift: begin
                    bit_cnt_d   = cnt_inc;
                    word_left_d = word_left_q - WL_W'(1);
                    shreg_d     = shreg_q << 1;
                    if (cnt_inc == ChainLenC) begin
                        state_d = StDone;
                    end else if (word_left_q == WL_W'(1)) begin
                        if (accept) begin
                            // Back-to-back word: next cycle sends its MSB with no bubble.
                            shreg_d     = cfg.cfg_data;
                            word_left_d = word_len;
                        end else begin
                            state_d = StLoad;
                        end
                    end
                end
                StDone: begin
                    if (start) begin
                        state_d   = StLoad;
                        bit_cnt_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        prog_clk_en_d = (state_d == StShift);
        ccff_head_d   = (state_d == StShift) ? shreg_d[WORD_W-1] : 1'b0;
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            word_left_q   <= '0;
            shreg_q       <= '0;
            ccff_head_q   <= 1'b0;
            prog_clk_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_left_q   <= word_left_d;
            shreg_q       <= shreg_d;
            ccff_head_q   <= ccff_head_d;
            prog_clk_en_q <= prog_clk_en_d;
        end
    end

    assign ccff_head   = ccff_head_q;
    assign prog_clk_en = prog_clk_en_q;
    assign busy        = (state_q == StLoad) | (state_q == StShift);
    assign done        = (state_q == StDone);

`ifdef CCFF_TAIL_CRC_EN
    logic [15:0] head_crc_q, head_crc_d;
    logic [15:0] tail_crc_q, tail_crc_d;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic [15:0] nxt;
        nxt = {crc[14:0], 1'b0};
        if (crc[15] ^ b) begin
            nxt = nxt ^ 16'h1021;
        end
        return nxt;
    endfunction

    // Accumulate both CRCs on every cycle the fabric captures a bit.
    always_comb begin
        head_crc_d = head_crc_q;
        tail_crc_d = tail_crc_q;
        if (start_acc) begin
            head_crc_d = 16'hFFFF;
            tail_crc_d = 16'hFFFF;
        end else if (prog_clk_en_q) begin
            head_crc_d = crc16_step(head_crc_q, ccff_head_q);
            tail_crc_d = crc16_step(tail_crc_q, ccff_tail);
        end
    end

    // CRC registers.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            head_crc_q <= 16'hFFFF;
            tail_crc_q <= 16'hFFFF;
        end else begin
            head_crc_q <= head_crc_d;
            tail_crc_q <= tail_crc_d;
        end
    end

    assign head_crc = head_crc_q;
    assign tail_crc = tail_crc_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Drives the configuration-chain head (ccff_head) of the tile column/row from a word-wide bitstream source.
- Serialises cfg words MSB-first onto the chain and produces a gating enable for the fabric prog_clk, so the chain advances only on valid bits.
- Counts exactly CHAIN_LEN shifted bits, then reports done.
- Sits directly upstream of the first tile's ccff_head; the last tile's ccff_tail returns here.

Parameters:
- CHAIN_LEN, 4096: total configuration bits in the chain (>=1). The internal bit counter width is clog2(CHAIN_LEN+1), a derived localparam.
- WORD_W, 32: width of the incoming bitstream word (>=2).

Ports:
- prog_clk  input  1  programming clock; all state is on its rising edge.
- prog_reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load.
- abort  input  1  synchronous cancel of a load in progress.
- cfg_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial bit into the chain; registered.
- prog_clk_en  output  1  fabric prog_clk gate enable; registered.
- ccff_tail  input  1  chain output loopback; used only by the optional feature.
- busy  output  1  load in progress.
- done  output  1  CHAIN_LEN bits delivered; sticky.

Behaviour:
- Reset (async, prog_reset_n=0): all state is cleared immediately.
  - Outputs: ccff_head=0, prog_clk_en=0, cfg_ready=0, busy=0, done=0.
  - FSM returns to IDLE and the counter goes to 0.
  - Reset mid-load abandons the load; there is no resume.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 -> LOAD; clear bit_cnt and done; busy=1 from the next cycle.
- LOAD:
  - cfg_ready=1 and prog_clk_en=0 (chain held).
  - On cfg_valid&cfg_ready: capture the word into shreg, set word_left = min(WORD_W, CHAIN_LEN-bit_cnt), go to SHIFT.
- SHIFT: each cycle
  - ccff_head = current MSB, prog_clk_en=1; shreg shifts left; bit_cnt+1; word_left-1.
  - The fabric captures ccff_head on the prog_clk edge that ends a cycle with prog_clk_en=1.
  - cfg_ready=1 only on the last bit of the current word, and only if bits remain after it.
  - If a handshake occurs on that last-bit cycle, the next word loads with no bubble (stay in SHIFT). Otherwise go to LOAD.
  - If the last bit of the chain is shifted (bit_cnt reaches CHAIN_LEN) -> DONE.
- Partial last word: when CHAIN_LEN mod WORD_W = r != 0, only the upper r bits of the final word are shifted; the lower bits are discarded.
- DONE:
  - done=1, busy=0, prog_clk_en=0, cfg_ready=0, ccff_head=0.
  - start -> LOAD (new load, done cleared).
- start while busy: ignored.
- abort (any state but IDLE):
  - Next edge: IDLE, prog_clk_en=0, cfg_ready=0, busy=0, done=0; bit_cnt cleared.
  - abort and start in the same cycle: abort wins, start is ignored.
- No words are accepted outside LOAD or the last-bit window of SHIFT.
- Bit count is exact: exactly CHAIN_LEN cycles with prog_clk_en=1 per completed load.
- Peak throughput is 1 bit/cycle with back-to-back valid words.

Optional Feature:
- Macro: CCFF_TAIL_CRC_EN.
- With the macro defined:
  - Adds outputs head_crc[15:0] and tail_crc[15:0], both CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no final XOR).
  - head_crc accumulates every ccff_head bit on prog_clk_en=1 cycles.
  - tail_crc accumulates ccff_tail on the same cycles, capturing the previous chain contents as they emerge.
  - Both are re-initialised on an accepted start and hold their value in DONE.
  - Comparing tail_crc of load N+1 with head_crc of load N verifies chain integrity.
- Without the macro: the ports and logic are absent; ccff_tail is unused.

Test Plan:
- Basic load: CHAIN_LEN=70, WORD_W=32; reset; start; words 0xA5A5A5A5, 0x0F0F0F0F, 0xFC000000 with valid held high -> exactly 70 prog_clk_en cycles, no bubbles; ccff_head sequence equals the word bits MSB-first with the last word truncated to its top 6 bits (111111); done=1 on the cycle after the 70th bit; busy=0.
- Starved source: same config, cfg_valid deasserted 5 cycles between words -> prog_clk_en=0 during the gaps, the shifted bit sequence is identical to the basic load, done asserts after 70 enabled cycles.
- Abort: abort asserted after the 40th shifted bit -> next cycle IDLE, prog_clk_en=0, busy=0, done=0; a new start with 3 words completes a full 70-bit load.
- Async reset mid-SHIFT: prog_reset_n pulled low between edges -> prog_clk_en, ccff_head, busy and cfg_ready go to 0 immediately; start after release behaves as the first load.
- Corner: CHAIN_LEN=64, WORD_W=32; start and abort asserted together in IDLE -> remains IDLE; then start with 2 words -> done after exactly 64 enabled cycles, and a 3rd offered word is not accepted (cfg_ready=0).
- CCFF_TAIL_CRC_EN: model the chain as a 70-flop shift register; load pattern P, then load P again -> tail_crc of the second load equals head_crc of the first.
